// File: rtl/calc_entry_controller.sv
// Calculator entry controller: builds two signed 3-digit BCD operands from keypad
// events, launches the arithmetic unit, and selects what the display shows.
module calc_entry_controller #(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int TIMER_W        = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        keyValid,
  input  logic [3:0]  keyCode,
  input  logic        aluDone,
  output logic        aluStart,
  output logic [1:0]  opSel,
  output logic [1:0]  stateEncoder,
  output logic [12:0] operand1,
  output logic [12:0] operand2,
  output logic        busy,
  output logic        errorFlag
);

  typedef enum logic [1:0] {ENTER1, ENTER2, CALC, RESULT} state_t;

  localparam logic [3:0] KEY_EQ   = 4'd13;
  localparam logic [3:0] KEY_SIGN = 4'd14;
  localparam logic [3:0] KEY_CLR  = 4'd15;

  state_t             state_q, state_d;
  logic [12:0]        op1_q, op1_d, op2_q, op2_d;
  logic [1:0]         cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic [1:0]         opSel_q, opSel_d;
  logic [1:0]         stateEnc_q, stateEnc_d;
  logic               aluStart_q, aluStart_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic [TIMER_W-1:0] timer_q, timer_d;

  logic        isDigit, isOper;
  logic [14:0] dig1, dig2, digFresh;

  // Returns {count, operand}; full operands and leading zeros leave it unchanged.
  function automatic logic [14:0] appendDigit(input logic [12:0] op, input logic [1:0] cnt,
                                              input logic [3:0] d);
    if (cnt == 2'd3 || (op[11:0] == 12'd0 && d == 4'd0)) return {cnt, op};
    return {cnt + 2'd1, op[12], op[7:0], d};
  endfunction

  assign isDigit  = (keyCode <= 4'd9);
  assign isOper   = (keyCode >= 4'd10) && (keyCode <= 4'd12);
  assign dig1     = appendDigit(op1_q, cnt1_q, keyCode);
  assign dig2     = appendDigit(op2_q, cnt2_q, keyCode);
  assign digFresh = appendDigit(13'd0, 2'd0, keyCode);

  always_comb begin
    state_d    = state_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    cnt1_d     = cnt1_q;
    cnt2_d     = cnt2_q;
    opSel_d    = opSel_q;
    aluStart_d = 1'b0;
    err_d      = err_q;
    timer_d    = timer_q;

    if (keyValid) err_d = 1'b0;

    if (keyValid && keyCode == KEY_CLR) begin
      state_d = ENTER1;
      op1_d   = 13'd0;
      op2_d   = 13'd0;
      cnt1_d  = 2'd0;
      cnt2_d  = 2'd0;
      opSel_d = 2'd0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ENTER1: begin
          if (keyValid) begin
            if (isDigit) begin
              {cnt1_d, op1_d} = dig1;
            end else if (keyCode == KEY_SIGN) begin
              op1_d[12] = ~op1_q[12];
            end else if (isOper) begin
              // keyCode 10/11/12 low bits 10/11/00 plus 2 wrap to 00/01/10
              opSel_d = keyCode[1:0] + 2'd2;
              op2_d   = 13'd0;
              cnt2_d  = 2'd0;
              state_d = ENTER2;
            end
          end
        end
        ENTER2: begin
          if (keyValid) begin
            if (isDigit) begin
              {cnt2_d, op2_d} = dig2;
            end else if (keyCode == KEY_SIGN) begin
              op2_d[12] = ~op2_q[12];
            end else if (isOper) begin
              if (cnt2_q == 2'd0) opSel_d = keyCode[1:0] + 2'd2;
            end else if (keyCode == KEY_EQ) begin
              aluStart_d = 1'b1;
              timer_d    = '0;
              state_d    = CALC;
            end
          end
        end
        CALC: begin
          if (aluDone) begin
            state_d = RESULT;
          end else if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = ENTER2;
            err_d   = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        RESULT: begin
          if (keyValid && isDigit) begin
            {cnt1_d, op1_d} = digFresh;
            op2_d   = 13'd0;
            cnt2_d  = 2'd0;
            state_d = ENTER1;
          end
        end
        default: state_d = ENTER1;
      endcase
    end

    busy_d = (state_d == CALC);
    case (state_d)
      ENTER1:  stateEnc_d = 2'b01;
      RESULT:  stateEnc_d = 2'b11;
      default: stateEnc_d = 2'b10;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ENTER1;
      op1_q      <= 13'd0;
      op2_q      <= 13'd0;
      cnt1_q     <= 2'd0;
      cnt2_q     <= 2'd0;
      opSel_q    <= 2'd0;
      stateEnc_q <= 2'b01;
      aluStart_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      cnt1_q     <= cnt1_d;
      cnt2_q     <= cnt2_d;
      opSel_q    <= opSel_d;
      stateEnc_q <= stateEnc_d;
      aluStart_q <= aluStart_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      timer_q    <= timer_d;
    end
  end

  assign aluStart     = aluStart_q;
  assign opSel        = opSel_q;
  assign stateEncoder = stateEnc_q;
  assign operand1     = op1_q;
  assign operand2     = op2_q;
  assign busy         = busy_q;
  assign errorFlag    = err_q;

endmodule

// File: tb/tb_calc_entry_controller.sv
// Self-checking bench for calc_entry_controller: directed scenarios with literal
// expectations plus random keypad traffic compared each cycle against a behavioural model.
module tb_calc_entry_controller;

  localparam int TIMEOUT = 1023;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        keyValid = 1'b0;
  logic [3:0]  keyCode = 4'd0;
  logic        aluDone = 1'b0;
  logic        aluStart;
  logic [1:0]  opSel;
  logic [1:0]  stateEncoder;
  logic [12:0] operand1;
  logic [12:0] operand2;
  logic        busy;
  logic        errorFlag;

  int checks = 0;
  int failures = 0;
  bit checkEn = 1'b0;

  // Model state: mode 0 entering operand1, 1 entering operand2, 2 calculating, 3 showing result.
  int mode, mag1, mag2, cnt1, cnt2, calcCycles, mOpSel, kc;
  bit neg1, neg2, mAluStart, mErr;

  calc_entry_controller #(.TIMEOUT_CYCLES(TIMEOUT), .TIMER_W(10)) dut (
    .clk(clk), .reset(reset), .keyValid(keyValid), .keyCode(keyCode), .aluDone(aluDone),
    .aluStart(aluStart), .opSel(opSel), .stateEncoder(stateEncoder), .operand1(operand1),
    .operand2(operand2), .busy(busy), .errorFlag(errorFlag)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] pack(input bit neg, input int mag);
    return {neg, 4'(mag / 100 % 10), 4'(mag / 10 % 10), 4'(mag % 10)};
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic enterDigit(inout int mag, inout int cnt, input int d);
    if (cnt < 3 && !(mag == 0 && d == 0)) begin
      mag = mag * 10 + d;
      cnt++;
    end
  endtask

  task automatic applyStimulus(input logic kv, input logic [3:0] code, input logic ad);
    keyValid = kv;
    keyCode  = code;
    aluDone  = ad;
    @(posedge clk);
    #1;
    keyValid = 1'b0;
    aluDone  = 1'b0;
  endtask

  task automatic key(input int code);
    applyStimulus(1'b1, 4'(code), 1'b0);
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      mode = 0; mag1 = 0; mag2 = 0; cnt1 = 0; cnt2 = 0; calcCycles = 0;
      neg1 = 0; neg2 = 0; mOpSel = 0; mAluStart = 0; mErr = 0;
    end else begin
      kc = int'(keyCode);
      mAluStart = 0;
      if (keyValid) mErr = 0;
      if (keyValid && kc == 15) begin
        mode = 0; mag1 = 0; mag2 = 0; cnt1 = 0; cnt2 = 0;
        neg1 = 0; neg2 = 0; mOpSel = 0;
      end else begin
        case (mode)
          0: if (keyValid) begin
            if (kc <= 9) enterDigit(mag1, cnt1, kc);
            else if (kc == 14) neg1 = !neg1;
            else if (kc >= 10 && kc <= 12) begin
              mOpSel = kc - 10; mag2 = 0; neg2 = 0; cnt2 = 0; mode = 1;
            end
          end
          1: if (keyValid) begin
            if (kc <= 9) enterDigit(mag2, cnt2, kc);
            else if (kc == 14) neg2 = !neg2;
            else if (kc >= 10 && kc <= 12) begin
              if (cnt2 == 0) mOpSel = kc - 10;
            end else if (kc == 13) begin
              mAluStart = 1; calcCycles = 0; mode = 2;
            end
          end
          2: if (aluDone) mode = 3;
             else begin
               calcCycles++;
               if (calcCycles == TIMEOUT) begin mode = 1; mErr = 1; end
             end
          default: if (keyValid && kc <= 9) begin
            mag1 = 0; cnt1 = 0; neg1 = 0; enterDigit(mag1, cnt1, kc);
            mag2 = 0; cnt2 = 0; neg2 = 0; mode = 0;
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (checkEn && !reset) begin
      checkOutput("cyc_stateEncoder", 16'(stateEncoder), (mode == 0) ? 16'd1 : (mode == 3) ? 16'd3 : 16'd2);
      checkOutput("cyc_busy", 16'(busy), 16'(mode == 2));
      checkOutput("cyc_aluStart", 16'(aluStart), 16'(mAluStart));
      checkOutput("cyc_errorFlag", 16'(errorFlag), 16'(mErr));
      checkOutput("cyc_opSel", 16'(opSel), 16'(mOpSel));
      checkOutput("cyc_operand1", 16'(operand1), 16'(pack(neg1, mag1)));
      checkOutput("cyc_operand2", 16'(operand2), 16'(pack(neg2, mag2)));
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int r;
    logic kvR, adR;
    logic [3:0] kcR;

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkEn = 1'b1;

    checkOutput("model_pack_neg", 16'(pack(1, 123)), 16'h1123);
    checkOutput("model_pack_pos", 16'(pack(0, 7)), 16'h0007);

    checkOutput("rst_stateEncoder", 16'(stateEncoder), 16'h1);
    checkOutput("rst_operand1", 16'(operand1), 16'h0);
    checkOutput("rst_operand2", 16'(operand2), 16'h0);
    checkOutput("rst_busy_err_start", {13'd0, busy, errorFlag, aluStart}, 16'h0);

    key(1); key(2); key(3); key(4);
    checkOutput("digits_saturate", 16'(operand1), 16'h0123);
    checkOutput("digits_state", 16'(stateEncoder), 16'h1);
    key(14);
    checkOutput("sign_toggle", 16'(operand1), 16'h1123);

    key(15); key(0); key(0); key(7);
    checkOutput("leading_zero", 16'(operand1), 16'h0007);
    key(10);
    checkOutput("plus_state", 16'(stateEncoder), 16'h2);
    checkOutput("plus_opSel", 16'(opSel), 16'h0);
    checkOutput("plus_operand2", 16'(operand2), 16'h0);

    key(15); key(5); key(11); key(12);
    checkOutput("op_replace", 16'(opSel), 16'h2);
    key(9); key(10);
    checkOutput("no_chain_opSel", 16'(opSel), 16'h2);
    checkOutput("no_chain_operand2", 16'(operand2), 16'h0009);

    key(15); key(9); key(12); key(8); key(13);
    checkOutput("eq_aluStart", 16'(aluStart), 16'h1);
    checkOutput("eq_busy", 16'(busy), 16'h1);
    applyStimulus(1'b0, 4'd0, 1'b0);
    checkOutput("aluStart_one_cycle", 16'(aluStart), 16'h0);
    repeat (3) applyStimulus(1'b0, 4'd0, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b1);
    checkOutput("done_state", 16'(stateEncoder), 16'h3);
    checkOutput("done_busy", 16'(busy), 16'h0);
    key(4);
    checkOutput("result_digit_op1", 16'(operand1), 16'h0004);
    checkOutput("result_digit_op2", 16'(operand2), 16'h0);
    checkOutput("result_digit_state", 16'(stateEncoder), 16'h1);

    key(10); key(2); key(13);
    n = 1;
    while (busy && n < 1100) begin
      applyStimulus(1'b0, 4'd0, 1'b0);
      if (busy) n++;
    end
    checkOutput("timeout_cycles", 16'(n), 16'(TIMEOUT));
    checkOutput("timeout_state", 16'(stateEncoder), 16'h2);
    checkOutput("timeout_err", 16'(errorFlag), 16'h1);
    applyStimulus(1'b0, 4'd0, 1'b1);
    checkOutput("late_done_state", 16'(stateEncoder), 16'h2);
    checkOutput("late_done_err", 16'(errorFlag), 16'h1);
    key(3);
    checkOutput("err_cleared", 16'(errorFlag), 16'h0);
    checkOutput("resume_operand2", 16'(operand2), 16'h0023);

    key(13);
    applyStimulus(1'b1, 4'd15, 1'b1);
    checkOutput("clear_wins_state", 16'(stateEncoder), 16'h1);
    checkOutput("clear_wins_ops", {3'd0, operand1}, 16'h0);
    checkOutput("clear_wins_op2", {3'd0, operand2}, 16'h0);
    checkOutput("clear_wins_busy", 16'(busy), 16'h0);

    key(6); key(12); key(1); key(13);
    checkOutput("pre_reset_busy", 16'(busy), 16'h1);
    #1 reset = 1'b1;
    #1;
    checkOutput("async_rst_state", 16'(stateEncoder), 16'h1);
    checkOutput("async_rst_flags", {13'd0, busy, errorFlag, aluStart}, 16'h0);
    checkOutput("async_rst_opSel", 16'(opSel), 16'h0);
    checkOutput("async_rst_op1", 16'(operand1), 16'h0);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 4000; i++) begin
      r   = int'($urandom_range(0, 99));
      kvR = 1'($urandom_range(0, 1));
      if (r < 55)      kcR = 4'($urandom_range(0, 9));
      else if (r < 70) kcR = 4'($urandom_range(10, 12));
      else if (r < 82) kcR = 4'd13;
      else if (r < 93) kcR = 4'd14;
      else             kcR = 4'd15;
      adR = ($urandom_range(0, 5) == 0);
      applyStimulus(kvR, kcR, adR);
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
